prog_mem_ctrl: RTL
==================

# prog_mem_ctrl

Program-memory responder on the far end of the sequencer's fetch port. It answers each fetch of ps_pm_add / ps_pm_cslt / ps_pm_wrb with a 32-bit instruction on pm_ps_op, half a clk_fetch cycle after the address. It also contains a boot-loader that fills the instruction array from a 16-bit host stream. While loading, it stalls the sequencer through pm_stallb and feeds it NOPs.

## Interface
- ADDR_W, 8: implemented address bits; the array depth is 2^ADDR_W 32-bit words.
- clk_fetch  in  1  fetch clock. Control state updates on the rising edge; read data updates on the falling edge.
- rst  in  1  reset, asynchronous, active-low.
- ps_pm_cslt  in  1  fetch request from the sequencer.
- ps_pm_wrb  in  1  write-bar. 0 is an illegal write attempt.
- ps_pm_add  in  16  fetch address.
- pm_ps_op  out  32  instruction to the sequencer/decoder.
- pm_stallb  out  1  active-low stall to the sequencer.
- ldr_start  in  1  single-cycle pulse that begins a boot load.
- ldr_len  in  16  number of instructions to load, starting at address 0. Sampled with ldr_start.
- ldr_valid  in  1  a host halfword is present.
- ldr_data  in  16  host halfword; low half of each instruction first.
- ldr_ready  out  1  the loader accepts a halfword.
- pm_boot_done  out  1  single-cycle pulse at the end of a load.
- pm_err  out  1  sticky error flag.

## Operation
- NOP_OP = 32'h0. The sequencer decodes it as no jump, no return, no stack operation and no compute.
- FSM states: S_RUN, S_LO, S_HI, S_FLUSH. Reset state is S_RUN.
- S_RUN
  - ldr_start=1 → clear pm_err.
  - len_eff = min(ldr_len, 2^ADDR_W). If ldr_len > 2^ADDR_W, set pm_err.
  - Clear the write pointer wp.
  - len_eff=0 → S_FLUSH; otherwise → S_LO.
- S_LO
  - ldr_ready=1.
  - A transfer (ldr_valid & ldr_ready) latches lo_reg=ldr_data → S_HI.
- S_HI
  - ldr_ready=1.
  - A transfer writes array[wp] = {ldr_data, lo_reg} and increments wp.
  - wp == len_eff after the increment → S_FLUSH; otherwise → S_LO.
  - wp never wraps because of the clamp.
- S_FLUSH: lasts one cycle. Assert pm_boot_done → S_RUN.
- ldr_start outside S_RUN is ignored.
- ldr_valid without ldr_ready is ignored and the data is not consumed.
- Fetch behaviour:
  - The read register is captured on the falling edge of clk_fetch.
  - If ps_pm_cslt=1, ps_pm_wrb=1, state S_RUN and ps_pm_add[15:ADDR_W]==0 → pm_ps_op = array[ps_pm_add[ADDR_W-1:0]].
  - If ps_pm_add[15:ADDR_W] != 0 → pm_ps_op = NOP_OP and pm_err is set.
  - If ps_pm_cslt=1 and ps_pm_wrb=0 → the array is unchanged, pm_ps_op = NOP_OP and pm_err is set.
  - If ps_pm_cslt=0 → pm_ps_op holds its value.
  - In any state other than S_RUN → pm_ps_op = NOP_OP.
- pm_stallb = 1 only in S_RUN. It goes low on the rising edge that accepts ldr_start.
- Reset values: pm_ps_op=0, pm_stallb=1, ldr_ready=0, pm_boot_done=0, pm_err=0, state=S_RUN, wp=0. Array contents are not reset.
- Reset during a load aborts it: state returns to S_RUN, no done pulse, already-written words are retained.

## Timing
- Fetch latency: address presented at rising edge t → pm_ps_op valid at the falling edge of cycle t. It is stable before the following clk_dcd edge.
- Load throughput: one halfword per cycle at most, so 2 cycles per instruction with ldr_valid held high.
- Load duration: ldr_start at edge t, with continuous ldr_valid and N≥1 instructions:
  - ldr_ready is high from t+1 to t+2N.
  - S_FLUSH occupies cycle t+2N+1, with pm_boot_done high in that cycle.
  - pm_stallb returns to 1 at edge t+2N+2.
- Read-during-write: an array write happens at a rising edge and is visible to the falling-edge read in the same cycle. Because of S_FLUSH, the first fetch after the stall is released sees the complete image.
- Simultaneous out-of-range fetch and ldr_start: the start wins and the fetch returns NOP_OP. pm_err is cleared by the start, then set again that cycle by the out-of-range fetch.

## Structure
- Package pm_pkg holds:
  - the state encoding (S_RUN, S_LO, S_HI, S_FLUSH),
  - NOP_OP,
  - the default ADDR_W,
  - a DATA_W=32 constant.
- Sub-module pm_sram holds the array: 2^ADDR_W × 32, one synchronous write port on the rising edge, one registered read port on the falling edge with a hold-when-disabled enable.
- prog_mem_ctrl contains the loader FSM, wp, lo_reg, the clamp/error logic and the output muxing.

## Test plan
- Load ldr_len=3 with halfwords 0x1111,0x2222,0x3333,0x4444,0x5555,0x6666:
  - pm_boot_done pulses at t+7.
  - Fetches of 0, 1, 2 return 0x22221111, 0x44443333, 0x66665555.
  - pm_stallb is low from t+1 through t+7.
- Fetch during a load (ps_pm_cslt=1, address 1) → pm_ps_op=0. Fetch with ps_pm_add=0x0100 at ADDR_W=8 → pm_ps_op=0, pm_err=1.
- Backpressure: drop ldr_valid for 3 cycles mid-instruction → the word is still written correctly and completion slips by 3 cycles.
- ldr_len=0 → no writes, pm_boot_done at t+1, pm_err=0. ldr_len=300 at ADDR_W=8 → pm_err=1 and exactly 256 words written.
- Assert rst after 2 of 4 instructions → pm_stallb=1, no done pulse, words 0-1 readable.
- ps_pm_wrb=0 with ps_pm_cslt=1 → array unchanged on readback, pm_err=1.

Source files
------------

// File: rtl/pm_pkg.sv
// Shared definitions for the program-memory responder and boot loader.
// Imported by pm_sram and prog_mem_ctrl.
package pm_pkg;

    localparam int PM_ADDR_W = 8;
    localparam int DATA_W    = 32;

    localparam logic [DATA_W-1:0] NOP_OP = '0;

    typedef enum logic [1:0] {
        S_RUN,
        S_LO,
        S_HI,
        S_FLUSH
    } pm_state_t;

endpackage

// File: rtl/pm_sram.sv
// Instruction array: rising-edge write port, falling-edge registered read
// port that holds when disabled and can substitute a NOP.
module pm_sram
    import pm_pkg::*;
#(
    parameter int ADDR_W = PM_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic              rd_nop,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Half a cycle after the write edge, so a same-cycle write is visible.
    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            rd_data <= NOP_OP;
        end else if (rd_en) begin
            rd_data <= rd_nop ? NOP_OP : mem[rd_addr];
        end
    end

endmodule

// File: rtl/prog_mem_ctrl.sv
// Program-memory responder: answers sequencer fetches and boot-loads the
// instruction array from a 16-bit host stream, stalling fetch meanwhile.
module prog_mem_ctrl
    import pm_pkg::*;
#(
    parameter int ADDR_W = PM_ADDR_W
) (
    input  logic              clk_fetch,
    input  logic              rst,
    input  logic              ps_pm_cslt,
    input  logic              ps_pm_wrb,
    input  logic [15:0]       ps_pm_add,
    output logic [DATA_W-1:0] pm_ps_op,
    output logic              pm_stallb,
    input  logic              ldr_start,
    input  logic [15:0]       ldr_len,
    input  logic              ldr_valid,
    input  logic [15:0]       ldr_data,
    output logic              ldr_ready,
    output logic              pm_boot_done,
    output logic              pm_err
);

    localparam int          DEPTH = 2**ADDR_W;
    localparam int          CNT_W = ADDR_W + 1;
    localparam logic [16:0] DEPTH_W17 = 17'(DEPTH);

    pm_state_t        state, state_n;
    logic [CNT_W-1:0] wp, wp_inc, len_eff, len_in;
    logic [15:0]      lo_reg;
    logic             start_acc, len_over, addr_bad;
    logic             fetch_err, we, rd_nop, err_n;

    assign addr_bad  = |ps_pm_add[15:ADDR_W];
    assign len_over  = {1'b0, ldr_len} > DEPTH_W17;
    assign len_in    = len_over ? CNT_W'(DEPTH) : ldr_len[CNT_W-1:0];
    assign start_acc = (state == S_RUN) && ldr_start;
    assign fetch_err = ps_pm_cslt && (addr_bad || !ps_pm_wrb);
    assign wp_inc    = wp + CNT_W'(1);
    assign rd_nop    = (state != S_RUN) || !ps_pm_wrb || addr_bad;

    // A start clears the sticky flag, but a same-cycle bad fetch re-sets it.
    assign err_n = (start_acc ? len_over : pm_err) | fetch_err;

    always_ff @(posedge clk_fetch or negedge rst) begin
        if (!rst) begin
            state <= S_RUN;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n      = state;
        ldr_ready    = 1'b0;
        pm_boot_done = 1'b0;
        pm_stallb    = 1'b0;
        we           = 1'b0;
        unique case (state)
            S_RUN: begin
                pm_stallb = 1'b1;
                if (ldr_start) begin
                    state_n = (len_in == '0) ? S_FLUSH : S_LO;
                end
            end
            S_LO: begin
                ldr_ready = 1'b1;
                if (ldr_valid) begin
                    state_n = S_HI;
                end
            end
            S_HI: begin
                ldr_ready = 1'b1;
                if (ldr_valid) begin
                    we      = 1'b1;
                    state_n = (wp_inc == len_eff) ? S_FLUSH : S_LO;
                end
            end
            S_FLUSH: begin
                pm_boot_done = 1'b1;
                state_n      = S_RUN;
            end
            default: state_n = S_RUN;
        endcase
    end

    always_ff @(posedge clk_fetch or negedge rst) begin
        if (!rst) begin
            wp      <= '0;
            len_eff <= '0;
            lo_reg  <= '0;
            pm_err  <= 1'b0;
        end else begin
            pm_err <= err_n;
            if (start_acc) begin
                wp      <= '0;
                len_eff <= len_in;
            end
            if (state == S_LO && ldr_valid) begin
                lo_reg <= ldr_data;
            end
            if (we) begin
                wp <= wp_inc;
            end
        end
    end

    pm_sram #(
        .ADDR_W(ADDR_W)
    ) u_sram (
        .clk     (clk_fetch),
        .rst     (rst),
        .we      (we),
        .wr_addr (wp[ADDR_W-1:0]),
        .wr_data ({ldr_data, lo_reg}),
        .rd_en   (ps_pm_cslt),
        .rd_nop  (rd_nop),
        .rd_addr (ps_pm_add[ADDR_W-1:0]),
        .rd_data (pm_ps_op)
    );

endmodule
